// File: rtl/nrisc_multiciclo.sv
// nrisc_multiciclo
// Multicycle nRisc core. An FSM steps each instruction through
// BUSCA -> DECOD -> EXEC -> [MEM] -> [ESCR]. Instruction and data memories
// sit outside the core behind request/ready handshakes, so either may stall.
//
// Handshake semantics (both memory ports): a request is held high, with its
// address/data/direction stable, until the matching ready is sampled high on
// a rising clock edge. That edge completes the transfer. A ready that arrives
// while no request is high is ignored. IReq and DReq are never high together.
//
// Ports
//   Clock   in            rising-edge clock
//   Reset   in            synchronous, active-high
//   IAddr   out [PC_W]    instruction address (= PC)
//   IReq    out           instruction fetch request
//   IReady  in            fetch done, IData valid in the same cycle
//   IData   in  [8]       instruction: opcode [7:5], rd [4:3], rs/imm3 [2:0]
//   DAddr   out [DATA_W]  data address (= R[rs])
//   DWData  out [DATA_W]  store data (= R[rd])
//   DReq    out           data access request
//   DWe     out           1 = store, 0 = load (meaningful only with DReq)
//   DReady  in            access done, DRData valid in the same cycle
//   DRData  in  [DATA_W]  load data
//   Estado  out [3]       FSM state, for debug/verification
module nrisc_multiciclo #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned PC_W     = 8,   // must be >= 3 (BEQ offset is 3 bits)
    parameter int unsigned RESET_PC = 0
) (
    input  logic              Clock,
    input  logic              Reset,
    output logic [PC_W-1:0]   IAddr,
    output logic              IReq,
    input  logic              IReady,
    input  logic [7:0]        IData,
    output logic [DATA_W-1:0] DAddr,
    output logic [DATA_W-1:0] DWData,
    output logic              DReq,
    output logic              DWe,
    input  logic              DReady,
    input  logic [DATA_W-1:0] DRData,
    output logic [2:0]        Estado
);

    localparam logic [2:0] BUSCA = 3'd0;
    localparam logic [2:0] DECOD = 3'd1;
    localparam logic [2:0] EXEC  = 3'd2;
    localparam logic [2:0] MEM   = 3'd3;
    localparam logic [2:0] ESCR  = 3'd4;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_ADDI = 3'b111;

    localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    logic [2:0]        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;      // R[rd] operand
    logic [DATA_W-1:0] b_q, b_d;      // R[rs] operand
    logic [DATA_W-1:0] res_q, res_d;  // value to write back in ESCR
    logic [DATA_W-1:0] regs_q [8];

    logic [2:0]        op;
    logic [1:0]        rd;
    logic [2:0]        rs;
    logic [DATA_W-1:0] imm_data;
    logic [PC_W-1:0]   imm_pc;
    logic [PC_W-1:0]   j_target;

    assign op       = ir_q[7:5];
    assign rd       = ir_q[4:3];
    assign rs       = ir_q[2:0];
    assign imm_data = {{(DATA_W-3){ir_q[2]}}, ir_q[2:0]};
    assign imm_pc   = {{(PC_W-3){ir_q[2]}}, ir_q[2:0]};
    // Low PC_W bits of R[rs]; zero-extended if the PC is wider than the data.
    assign j_target = PC_W'(b_q);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            BUSCA: begin
                if (IReady) begin
                    ir_d    = IData;
                    state_d = DECOD;
                end
            end
            DECOD: begin
                a_d     = regs_q[{1'b0, rd}];
                b_d     = regs_q[rs];
                state_d = EXEC;
            end
            EXEC: begin
                // Default path: sequential PC, result written back in ESCR.
                pc_d    = pc_q + PC_ONE;
                state_d = ESCR;
                case (op)
                    OP_ADD:       res_d = a_q + b_q;
                    OP_SUB:       res_d = a_q - b_q;
                    OP_MOV:       res_d = b_q;
                    OP_ADDI:      res_d = a_q + imm_data;
                    OP_LW, OP_SW: state_d = MEM;
                    OP_BEQ: begin
                        state_d = BUSCA;
                        if (a_q == regs_q[7]) pc_d = pc_q + PC_ONE + imm_pc;
                    end
                    default: begin  // J
                        state_d = BUSCA;
                        pc_d    = j_target;
                    end
                endcase
            end
            MEM: begin
                if (DReady) begin
                    if (op == OP_LW) begin
                        res_d   = DRData;
                        state_d = ESCR;
                    end else begin
                        state_d = BUSCA;
                    end
                end
            end
            ESCR:    state_d = BUSCA;
            default: state_d = BUSCA;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= BUSCA;
            pc_q    <= PC_RST;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    // Register file: only R0..R3 are writable as rd; R4..R7 stay at reset value.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else if (state_q == ESCR) begin
            regs_q[{1'b0, rd}] <= res_q;
        end
    end

    // Operand registers hold still through MEM, so DAddr/DWData are stable
    // for the whole data request.
    assign IAddr  = pc_q;
    assign IReq   = (state_q == BUSCA);
    assign DAddr  = b_q;
    assign DWData = a_q;
    assign DReq   = (state_q == MEM);
    assign DWe    = (state_q == MEM) && (op == OP_SW);
    assign Estado = state_q;

endmodule

// File: tb/tb_nrisc_multiciclo.sv
// Testbench for nrisc_multiciclo (DATA_W=16, PC_W=4).
// Memories are modelled in the bench; expected stores go to a queue and are
// popped when the core performs a store. Register contents are observed
// through stores to data memory.
module tb_nrisc_multiciclo;

    localparam int DATA_W = 16;
    localparam int PC_W   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [PC_W-1:0]   iaddr;
    logic              ireq;
    logic              iready;
    logic [7:0]        idata;
    logic [DATA_W-1:0] daddr;
    logic [DATA_W-1:0] dwdata;
    logic              dreq;
    logic              dwe;
    logic              dready;
    logic [DATA_W-1:0] drdata;
    logic [2:0]        estado;

    always #5 clk = ~clk;

    nrisc_multiciclo #(.DATA_W(DATA_W), .PC_W(PC_W), .RESET_PC(0)) dut (
        .Clock (clk),
        .Reset (rst),
        .IAddr (iaddr),
        .IReq  (ireq),
        .IReady(iready),
        .IData (idata),
        .DAddr (daddr),
        .DWData(dwdata),
        .DReq  (dreq),
        .DWe   (dwe),
        .DReady(dready),
        .DRData(drdata),
        .Estado(estado)
    );

    logic [7:0]        imem [16];
    logic [DATA_W-1:0] dmem [256];
    logic [31:0]       exp_q [$];   // {address, data} of expected stores

    int checks   = 0;
    int failures = 0;
    bit sb_on    = 1'b1;
    bit wait_rand = 1'b0;
    int i_wait   = 0;
    int d_wait   = 0;
    int i_cnt    = 0;
    int d_cnt    = 0;
    bit in_i     = 1'b0;
    bit in_d     = 1'b0;
    int fetches  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Memory responders, evaluated just after each clock edge.
    task automatic respond();
        if (ireq) begin
            if (!in_i) begin
                in_i  = 1'b1;
                i_cnt = wait_rand ? int'($urandom_range(0, 2)) : i_wait;
            end
            if (i_cnt > 0) begin
                iready = 1'b0;
                i_cnt--;
            end else begin
                iready = 1'b1;
                idata  = imem[iaddr];
            end
        end else begin
            in_i   = 1'b0;
            iready = 1'($urandom_range(0, 1));
            idata  = 8'($urandom_range(0, 255));
        end
        if (dreq) begin
            if (!in_d) begin
                in_d  = 1'b1;
                d_cnt = wait_rand ? int'($urandom_range(0, 2)) : d_wait;
            end
            if (d_cnt > 0) begin
                dready = 1'b0;
                d_cnt--;
            end else begin
                dready = 1'b1;
                drdata = dmem[daddr[7:0]];
            end
        end else begin
            in_d   = 1'b0;
            dready = 1'($urandom_range(0, 1));
            drdata = DATA_W'($urandom_range(0, 65535));
        end
    endtask

    task automatic step();
        bit                hold_i, hold_d;
        logic [PC_W-1:0]   p_iaddr;
        logic [DATA_W-1:0] p_daddr, p_dwdata;
        logic              p_dwe;
        hold_i   = !rst && ireq && !iready;
        hold_d   = !rst && dreq && !dready;
        p_iaddr  = iaddr;
        p_daddr  = daddr;
        p_dwdata = dwdata;
        p_dwe    = dwe;
        if (!rst && ireq && iready) fetches++;
        if (!rst && dreq && dready && dwe) begin
            dmem[daddr[7:0]] = dwdata;
            if (sb_on) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL unexpected_store observed=0x%0h expected=none", {daddr, dwdata});
                end else begin
                    chk("store", {daddr, dwdata}, exp_q.pop_front());
                end
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            in_i = 1'b0;
            in_d = 1'b0;
        end
        chk("no_overlap", ireq && dreq, 1'b0);
        if (hold_i) chk("ireq_hold", {ireq, iaddr}, {1'b1, p_iaddr});
        if (hold_d) chk("dreq_hold", {dreq, dwe, daddr, dwdata}, {1'b1, p_dwe, p_daddr, p_dwdata});
        respond();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic wait_fetch(input string tag, input logic [PC_W-1:0] addr, input int limit);
        int n = 0;
        while (!(estado === 3'd0 && iaddr === addr) && n < limit) begin
            step();
            n++;
        end
        chk(tag, {estado, iaddr}, {3'd0, addr});
    endtask

    task automatic drain(input string tag, input int limit);
        int n = 0;
        while (exp_q.size() > 0 && n < limit) begin
            step();
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 16; i++) imem[i] = 8'hC9;  // MOV R1,R1
    endtask

    initial begin
        int lat;
        int dcyc;
        int n;
        rst    = 1'b1;
        iready = 1'b0;
        dready = 1'b0;
        idata  = 8'h00;
        drdata = '0;
        for (int i = 0; i < 256; i++) dmem[i] = '0;
        fill_nop();

        // Reset state
        do_reset(2);
        chk("rst_estado", estado, 3'd0);
        chk("rst_ireq", ireq, 1'b1);
        chk("rst_iaddr", iaddr, 4'd0);
        chk("rst_dreq", dreq, 1'b0);
        chk("rst_dwe", dwe, 1'b0);

        // ADDI R1,+3 ; ADDI R1,-1 ; SW R1,[R0]
        fill_nop();
        imem[0] = 8'hEB;
        imem[1] = 8'hEF;
        imem[2] = 8'h68;
        exp_q.push_back({16'h0000, 16'h0002});
        do_reset(1);
        repeat (8) step();
        chk("addi_pc", iaddr, 4'd2);
        chk("addi_estado", estado, 3'd0);
        drain("addi_drain", 20);

        // LW R1,[R0] ; LW R2,[R1] (3 wait cycles) ; SW R2,[R0] ; LW R1,[R1] ; SW R1,[R1]
        fill_nop();
        imem[0] = 8'h48;
        imem[1] = 8'h51;
        imem[2] = 8'h70;
        imem[3] = 8'h49;
        imem[4] = 8'h69;
        dmem[8'h00] = 16'h0010;
        dmem[8'h10] = 16'h00A5;
        exp_q.push_back({16'h0000, 16'h00A5});
        exp_q.push_back({16'h00A5, 16'h00A5});
        do_reset(1);
        wait_fetch("lw_reach1", 4'd1, 20);
        d_wait = 3;
        lat    = 0;
        dcyc   = 0;
        do begin
            if (dreq) dcyc++;
            step();
            lat++;
        end while (estado !== 3'd0 && lat < 30);
        d_wait = 0;
        chk("lw_latency", lat, 8);
        chk("lw_dreq_cycles", dcyc, 4);
        drain("lw_drain", 60);

        // BEQ R0,-2 at PC=5, taken (R0 == R7 == 0)
        fill_nop();
        imem[5] = 8'h86;
        do_reset(1);
        wait_fetch("beq_t_reach", 4'd5, 40);
        repeat (3) step();
        chk("beq_taken_pc", iaddr, 4'd4);
        chk("beq_taken_estado", estado, 3'd0);

        // Same BEQ, not taken (ADDI R0,+1 first)
        imem[0] = 8'hE1;
        do_reset(1);
        wait_fetch("beq_nt_reach", 4'd5, 40);
        repeat (3) step();
        chk("beq_not_taken_pc", iaddr, 4'd6);

        // PC wrap on MOV at PC=15
        fill_nop();
        do_reset(1);
        wait_fetch("wrap_reach", 4'd15, 80);
        repeat (4) step();
        chk("wrap_pc", iaddr, 4'd0);
        chk("wrap_estado", estado, 3'd0);

        // BEQ R3,+1 at PC=15, taken: offset wraps to 1
        imem[15] = 8'h99;
        do_reset(1);
        wait_fetch("beq_wrap_reach", 4'd15, 80);
        repeat (3) step();
        chk("beq_wrap_pc", iaddr, 4'd1);

        // ADDI R1,+1 ; SUB R3,R1 ; SW R3,[R0] ; J R3 ; (15) SW R3,[R3]
        fill_nop();
        imem[0]  = 8'hE9;
        imem[1]  = 8'h39;
        imem[2]  = 8'h78;
        imem[3]  = 8'hA3;
        imem[15] = 8'h7B;
        exp_q.push_back({16'h0000, 16'hFFFF});
        exp_q.push_back({16'hFFFF, 16'hFFFF});
        do_reset(1);
        wait_fetch("j_reach", 4'd3, 40);
        repeat (3) step();
        chk("j_target_pc", iaddr, 4'd15);
        drain("sub_drain", 30);

        // Reset held 2 cycles during a stalled SW
        fill_nop();
        imem[0] = 8'hEB;
        imem[1] = 8'h68;
        dmem[0] = 16'h0055;
        d_wait  = 10;
        do_reset(1);
        n = 0;
        while (estado !== 3'd3 && n < 30) begin
            step();
            n++;
        end
        chk("sw_in_mem_dreq", dreq, 1'b1);
        chk("sw_in_mem_dwe", dwe, 1'b1);
        do_reset(2);
        chk("mid_rst_dreq", dreq, 1'b0);
        chk("mid_rst_dwe", dwe, 1'b0);
        chk("mid_rst_ireq", ireq, 1'b1);
        chk("mid_rst_estado", estado, 3'd0);
        chk("mid_rst_pc", iaddr, 4'd0);
        chk("mid_rst_mem", dmem[0], 16'h0055);
        d_wait = 0;
        // R1 must restart from 0, so the SW now stores 3
        exp_q.push_back({16'h0000, 16'h0003});
        drain("post_rst_drain", 30);

        // Random program with random wait states
        sb_on     = 1'b0;
        wait_rand = 1'b1;
        for (int i = 0; i < 16; i++) imem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 256; i++) dmem[i] = DATA_W'($urandom_range(0, 65535));
        do_reset(1);
        fetches = 0;
        n = 0;
        while (fetches < 1000 && n < 15000) begin
            step();
            n++;
        end
        chk("random_fetches", fetches >= 1000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
